// File: rtl/tl_txn_checker.sv
`default_nettype none
// ============================================================================
// Module   : tl_txn_checker
// Brief    : Passive TileLink-C transaction checker for one A/D/E link.
//            Tracks pending requests per source, multi-beat bursts and
//            Grant/GrantAck pairing; latches the first protocol error and
//            counts A first beats and D last beats.
//            Optional stall watchdog: define TL_CHECKER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tl_txn_checker #(
    parameter int SOURCE_W    = 4,
    parameter int SINK_W      = 2,
    parameter int DATA_W      = 64,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                a_valid_i,
    input  logic                a_ready_i,
    input  logic [2:0]          a_opcode_i,
    input  logic [3:0]          a_size_i,
    input  logic [SOURCE_W-1:0] a_source_i,
    input  logic                d_valid_i,
    input  logic                d_ready_i,
    input  logic [2:0]          d_opcode_i,
    input  logic [3:0]          d_size_i,
    input  logic [SOURCE_W-1:0] d_source_i,
    input  logic [SINK_W-1:0]   d_sink_i,
    input  logic                e_valid_i,
    input  logic                e_ready_i,
    input  logic [SINK_W-1:0]   e_sink_i,
    output logic                err_o,
    output logic [2:0]          err_code_o,
    output logic [SOURCE_W-1:0] err_id_o,
    output logic [SOURCE_W:0]   outstanding_o,
    output logic [CNT_W-1:0]    a_cnt_o,
    output logic [CNT_W-1:0]    d_cnt_o
);

    localparam int c_NSRC    = 2**SOURCE_W;
    localparam int c_NSINK   = 2**SINK_W;
    localparam int c_LOG2_BB = $clog2(DATA_W/8);

    // Expected response class stored per pending source
    localparam logic [1:0] c_CLS_ACK     = 2'd0;
    localparam logic [1:0] c_CLS_ACKDATA = 2'd1;
    localparam logic [1:0] c_CLS_GRANT   = 2'd2;

    // Beats in a message: one unless it carries data wider than a beat
    function automatic logic [15:0] f_beats(input logic [3:0] size, input logic has_data);
        logic [15:0] beats;
        beats = 16'd1;
        if (has_data && (size > 4'(c_LOG2_BB)))
            beats = 16'd1 << (size - 4'(c_LOG2_BB));
        return beats;
    endfunction

    // Response class implied by a request opcode
    function automatic logic [1:0] f_cls(input logic [2:0] op);
        logic [1:0] cls;
        case (op)
            3'd2, 3'd3, 3'd4: cls = c_CLS_ACKDATA;
            3'd6, 3'd7:       cls = c_CLS_GRANT;
            default:          cls = c_CLS_ACK;
        endcase
        return cls;
    endfunction

    logic                r_err;
    logic [2:0]          r_err_code;
    logic [SOURCE_W-1:0] r_err_id;
    logic [SOURCE_W:0]   r_outstanding;
    logic [CNT_W-1:0]    r_a_cnt;
    logic [CNT_W-1:0]    r_d_cnt;
    logic [15:0]         r_a_left;
    logic [15:0]         r_d_left;
    logic [c_NSRC-1:0]   r_pend;
    logic [1:0]          r_cls [c_NSRC];
    logic [c_NSINK-1:0]  r_gpend;

    logic w_a_fire, w_d_fire, w_e_fire;
    logic w_a_first, w_d_first, w_d_last;
    logic [15:0] w_a_beats, w_d_beats;
    logic w_d_hit, w_d_clr, w_d_is_grant, w_g_set, w_cls_ok;
    logic w_a_start, w_a_busy, w_a_alloc, w_e_hit, w_e_clr;
    logic w_err1, w_err2, w_err3, w_err4, w_err5;
    logic w_timeout;
    logic [SOURCE_W-1:0] w_low_src;
    logic [c_NSRC-1:0]   w_pend_nxt;
    logic [c_NSINK-1:0]  w_gpend_nxt;
    logic                w_any_err;
    logic [2:0]          w_code;
    logic [SOURCE_W-1:0] w_id;

    assign w_a_fire  = a_valid_i & a_ready_i;
    assign w_d_fire  = d_valid_i & d_ready_i;
    assign w_e_fire  = e_valid_i & e_ready_i;

    assign w_a_first = (r_a_left == 16'd0);
    assign w_d_first = (r_d_left == 16'd0);
    assign w_a_beats = f_beats(a_size_i, (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1));
    assign w_d_beats = f_beats(d_size_i, (d_opcode_i == 3'd1) || (d_opcode_i == 3'd5));
    assign w_d_last  = w_d_first ? (w_d_beats == 16'd1) : (r_d_left == 16'd1);

    // D is judged against the table as it stood before this cycle
    assign w_d_hit      = r_pend[d_source_i];
    assign w_d_clr      = w_d_fire & w_d_last & w_d_hit;
    assign w_d_is_grant = (d_opcode_i == 3'd4) || (d_opcode_i == 3'd5);
    assign w_g_set      = w_d_fire & w_d_last & w_d_is_grant;

    // A sees the table after this cycle's D clear, so same-source reuse is legal
    assign w_a_start = w_a_fire & w_a_first;
    assign w_a_busy  = r_pend[a_source_i] & ~(w_d_clr & (d_source_i == a_source_i));
    assign w_a_alloc = w_a_start & ~w_a_busy;

    // E is judged against grants recorded before this cycle
    assign w_e_hit = r_gpend[e_sink_i];
    assign w_e_clr = w_e_fire & w_e_hit;

    assign w_err1 = w_d_fire & ~w_d_hit;
    assign w_err2 = w_a_start & w_a_busy;
    assign w_err3 = w_d_fire & w_d_hit & w_d_first & ~w_cls_ok;
    assign w_err4 = w_g_set & r_gpend[d_sink_i];
    assign w_err5 = w_e_fire & ~w_e_hit;

    // Response opcode must belong to the class stored at request time
    always_comb begin
        w_cls_ok = 1'b0;
        case (r_cls[d_source_i])
            c_CLS_ACK:     w_cls_ok = (d_opcode_i == 3'd0);
            c_CLS_ACKDATA: w_cls_ok = (d_opcode_i == 3'd1);
            c_CLS_GRANT:   w_cls_ok = w_d_is_grant;
            default:       w_cls_ok = 1'b0;
        endcase
    end

    // Next pending and grant tables in D-clear, A-allocate, E-clear order
    always_comb begin
        w_pend_nxt  = r_pend;
        w_gpend_nxt = r_gpend;
        if (w_d_clr)   w_pend_nxt[d_source_i] = 1'b0;
        if (w_a_alloc) w_pend_nxt[a_source_i] = 1'b1;
        if (w_g_set)   w_gpend_nxt[d_sink_i]  = 1'b1;
        if (w_e_clr)   w_gpend_nxt[e_sink_i]  = 1'b0;
    end

    // Lowest code among this cycle's violations wins
    always_comb begin
        w_any_err = 1'b1;
        w_code    = 3'd0;
        w_id      = '0;
        if (w_err1) begin
            w_code = 3'd1; w_id = d_source_i;
        end else if (w_err2) begin
            w_code = 3'd2; w_id = a_source_i;
        end else if (w_err3) begin
            w_code = 3'd3; w_id = d_source_i;
        end else if (w_err4) begin
            w_code = 3'd4; w_id = SOURCE_W'(d_sink_i);
        end else if (w_err5) begin
            w_code = 3'd5; w_id = SOURCE_W'(e_sink_i);
        end else if (w_timeout) begin
            w_code = 3'd6; w_id = w_low_src;
        end else begin
            w_any_err = 1'b0;
        end
    end

`ifdef TL_CHECKER_TIMEOUT_EN
    localparam int c_STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [c_STALL_W-1:0] r_stall;

    // Stall counter saturates at the limit so the watchdog fires once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_stall <= '0;
        else if (w_d_fire || (r_outstanding == '0))
            r_stall <= '0;
        else if (r_stall != c_STALL_W'(TIMEOUT_CYC))
            r_stall <= r_stall + 1'b1;
    end

    assign w_timeout = !w_d_fire && (r_outstanding != '0) &&
                       (r_stall == c_STALL_W'(TIMEOUT_CYC - 1));

    // Report the lowest-numbered pending source on a timeout
    always_comb begin
        w_low_src = '0;
        for (int i = c_NSRC - 1; i >= 0; i--)
            if (r_pend[i]) w_low_src = SOURCE_W'(i);
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC > 0);
    assign w_timeout        = 1'b0;
    assign w_low_src        = '0;
`endif

    // Beat trackers, tables, counters and the first-error latch
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_left      <= '0;
            r_d_left      <= '0;
            r_pend        <= '0;
            r_gpend       <= '0;
            r_outstanding <= '0;
            r_a_cnt       <= '0;
            r_d_cnt       <= '0;
            r_err         <= 1'b0;
            r_err_code    <= '0;
            r_err_id      <= '0;
            for (int i = 0; i < c_NSRC; i++) r_cls[i] <= c_CLS_ACK;
        end else begin
            if (w_a_fire) r_a_left <= w_a_first ? (w_a_beats - 16'd1) : (r_a_left - 16'd1);
            if (w_d_fire) r_d_left <= w_d_first ? (w_d_beats - 16'd1) : (r_d_left - 16'd1);
            r_pend  <= w_pend_nxt;
            r_gpend <= w_gpend_nxt;
            if (w_a_alloc) r_cls[a_source_i] <= f_cls(a_opcode_i);
            if (w_a_alloc && !w_d_clr)      r_outstanding <= r_outstanding + 1'b1;
            else if (!w_a_alloc && w_d_clr) r_outstanding <= r_outstanding - 1'b1;
            if (w_a_start)             r_a_cnt <= r_a_cnt + 1'b1;
            if (w_d_fire && w_d_last)  r_d_cnt <= r_d_cnt + 1'b1;
            if (!r_err && w_any_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
                r_err_id   <= w_id;
            end
        end
    end

    assign err_o         = r_err;
    assign err_code_o    = r_err_code;
    assign err_id_o      = r_err_id;
    assign outstanding_o = r_outstanding;
    assign a_cnt_o       = r_a_cnt;
    assign d_cnt_o       = r_d_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tl_txn_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_txn_checker
// Brief    : Self-checking bench for tl_txn_checker: directed vector table,
//            multi-cycle corner sequences and randomized traffic against a
//            message-level reference model. Honours TL_CHECKER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_txn_checker;

    localparam int c_TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, a_ready, d_valid, d_ready, e_valid, e_ready;
    logic [2:0] a_opcode, d_opcode;
    logic [3:0] a_size, d_size, a_source, d_source;
    logic [1:0] d_sink, e_sink;
    logic       err;
    logic [2:0] err_code;
    logic [3:0] err_id;
    logic [4:0] outstanding;
    logic [3:0] a_cnt, d_cnt;

    int n_checks = 0;
    int n_errors = 0;

    tl_txn_checker #(
        .SOURCE_W(4), .SINK_W(2), .DATA_W(64), .CNT_W(4), .TIMEOUT_CYC(c_TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_valid_i(a_valid), .a_ready_i(a_ready), .a_opcode_i(a_opcode),
        .a_size_i(a_size), .a_source_i(a_source),
        .d_valid_i(d_valid), .d_ready_i(d_ready), .d_opcode_i(d_opcode),
        .d_size_i(d_size), .d_source_i(d_source), .d_sink_i(d_sink),
        .e_valid_i(e_valid), .e_ready_i(e_ready), .e_sink_i(e_sink),
        .err_o(err), .err_code_o(err_code), .err_id_o(err_id),
        .outstanding_o(outstanding), .a_cnt_o(a_cnt), .d_cnt_o(d_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (message level) ----------------
    bit pend [16];
    int req_op [16];
    bit gpend [4];
    int m_out, m_acnt, m_dcnt, m_err, m_code, m_id, m_stall, m_a_left, m_d_left;
    int bc, bid;

    function automatic int nbeats(input int size, input bit data);
        int bytes;
        bytes = 1 << size;
        if (!data || bytes <= 8) return 1;
        return bytes / 8;
    endfunction

    function automatic bit class_ok(input int req, input int dop);
        case (req)
            4:       return dop == 1;
            0, 1:    return dop == 0;
            6, 7:    return (dop == 4) || (dop == 5);
            default: return 1'b0;
        endcase
    endfunction

    task automatic note(input int code, input int id);
        if (code < bc) begin bc = code; bid = id; end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin pend[i] = 0; req_op[i] = 0; end
        for (int i = 0; i < 4; i++) gpend[i] = 0;
        m_out = 0; m_acnt = 0; m_dcnt = 0; m_err = 0; m_code = 0; m_id = 0;
        m_stall = 0; m_a_left = 0; m_d_left = 0;
    endtask

    task automatic model_step();
        bit gp_old [4];
        int out_old, low, rem, src;
        bit first;
        bc = 7; bid = 0;
        out_old = m_out;
        gp_old = gpend;
        low = -1;
        for (int i = 0; i < 16; i++) if (pend[i] && low < 0) low = i;
        if (d_valid && d_ready) begin
            src   = int'(d_source);
            first = (m_d_left == 0);
            rem   = first ? nbeats(int'(d_size), (d_opcode == 1) || (d_opcode == 5)) : m_d_left;
            m_d_left = rem - 1;
            if (!pend[src]) note(1, src);
            else if (first && !class_ok(req_op[src], int'(d_opcode))) note(3, src);
            if (rem == 1) begin
                m_dcnt++;
                if (pend[src]) begin pend[src] = 0; m_out--; end
                if ((d_opcode == 4) || (d_opcode == 5)) begin
                    if (gp_old[d_sink]) note(4, int'(d_sink));
                    gpend[d_sink] = 1;
                end
            end
        end
        if (a_valid && a_ready) begin
            if (m_a_left == 0) begin
                m_acnt++;
                if (pend[a_source]) note(2, int'(a_source));
                else begin pend[a_source] = 1; req_op[a_source] = int'(a_opcode); m_out++; end
                m_a_left = nbeats(int'(a_size), a_opcode <= 1) - 1;
            end else begin
                m_a_left--;
            end
        end
        if (e_valid && e_ready) begin
            if (!gp_old[e_sink]) note(5, int'(e_sink));
            else gpend[e_sink] = 0;
        end
`ifdef TL_CHECKER_TIMEOUT_EN
        if ((d_valid && d_ready) || out_old == 0) m_stall = 0;
        else begin
            if (m_stall == c_TO - 1) note(6, low);
            if (m_stall < c_TO) m_stall++;
        end
`endif
        if (!m_err && bc < 7) begin m_err = 1; m_code = bc; m_id = bid; end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk6(input string tag, input int o, input int ac, input int dc,
                        input int e, input int c, input int id);
        chk({tag, ".outstanding"}, int'(outstanding), o);
        chk({tag, ".a_cnt"}, int'(a_cnt), ac);
        chk({tag, ".d_cnt"}, int'(d_cnt), dc);
        chk({tag, ".err"}, int'(err), e);
        chk({tag, ".code"}, int'(err_code), c);
        chk({tag, ".id"}, int'(err_id), id);
    endtask

    task automatic set_in(input bit av, input int aop, input int asz, input int asrc,
                          input bit dv, input int dop, input int dsz, input int dsrc,
                          input int dsink, input bit ev, input int esink);
        a_valid = av; a_ready = 1'b1; a_opcode = 3'(aop); a_size = 4'(asz); a_source = 4'(asrc);
        d_valid = dv; d_ready = 1'b1; d_opcode = 3'(dop); d_size = 4'(dsz); d_source = 4'(dsrc);
        d_sink = 2'(dsink); e_valid = ev; e_ready = 1'b1; e_sink = 2'(esink);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst;
        bit av; int aop; int asz; int asrc;
        bit dv; int dop; int dsz; int dsrc; int dsink;
        bit ev; int esink;
        int out; int acnt; int dcnt; int err; int code; int id;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit rst, bit av, int aop, int asz, int asrc,
                                bit dv, int dop, int dsz, int dsrc, int dsink,
                                bit ev, int esink, int out, int acnt, int dcnt,
                                int e, int code, int id);
        vec_t v;
        v.rst = rst; v.av = av; v.aop = aop; v.asz = asz; v.asrc = asrc;
        v.dv = dv; v.dop = dop; v.dsz = dsz; v.dsrc = dsrc; v.dsink = dsink;
        v.ev = ev; v.esink = esink; v.out = out; v.acnt = acnt; v.dcnt = dcnt;
        v.err = e; v.code = code; v.id = id;
        return v;
    endfunction

    // ---------------- randomized driver ----------------
    task automatic rand_drive();
        int q[$];
        int src;
        if (m_a_left == 0) begin
            case ($urandom_range(0, 4))
                0: a_opcode = 3'd0;
                1: a_opcode = 3'd1;
                2: a_opcode = 3'd4;
                3: a_opcode = 3'd6;
                default: a_opcode = 3'd7;
            endcase
            a_size   = 4'($urandom_range(0, 6));
            a_source = 4'($urandom_range(0, 7));
        end
        a_valid = ($urandom_range(0, 3) != 0);
        a_ready = ($urandom_range(0, 3) != 0);
        if (m_d_left == 0) begin
            for (int i = 0; i < 16; i++) if (pend[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                src = q[$urandom_range(0, q.size() - 1)];
            else
                src = int'($urandom_range(0, 7));
            d_source = 4'(src);
            if (pend[src] && $urandom_range(0, 4) != 0) begin
                case (req_op[src])
                    4:       d_opcode = 3'd1;
                    0, 1:    d_opcode = 3'd0;
                    default: d_opcode = ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd5;
                endcase
            end else begin
                case ($urandom_range(0, 4))
                    0: d_opcode = 3'd0;
                    1: d_opcode = 3'd1;
                    2: d_opcode = 3'd4;
                    3: d_opcode = 3'd5;
                    default: d_opcode = 3'd6;
                endcase
            end
            d_size = 4'($urandom_range(0, 6));
            d_sink = 2'($urandom_range(0, 3));
        end
        d_valid = ($urandom_range(0, 2) != 0);
        d_ready = ($urandom_range(0, 3) != 0);
        q.delete();
        for (int i = 0; i < 4; i++) if (gpend[i]) q.push_back(i);
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
            e_sink = 2'(q[$urandom_range(0, q.size() - 1)]);
        else
            e_sink = 2'($urandom_range(0, 3));
        e_valid = ($urandom_range(0, 3) == 0);
        e_ready = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();

        // Get/AccessAckData round trip
        vt.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0));
        vt.push_back(mk(0, 1,4,3,3, 0,0,0,0,0, 0,0, 1,1,0,0,0,0));
        vt.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0, 1,1,0,0,0,0));
        vt.push_back(mk(0, 0,0,0,0, 1,1,3,3,0, 0,0, 0,1,1,0,0,0));
        // D with nothing pending, later error keeps the first code
        vt.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0));
        vt.push_back(mk(0, 0,0,0,0, 1,0,0,5,0, 0,0, 0,0,1,1,1,5));
        vt.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 1,2, 0,0,1,1,1,5));
        // Duplicate Get
        vt.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0));
        vt.push_back(mk(0, 1,4,2,1, 0,0,0,0,0, 0,0, 1,1,0,0,0,0));
        vt.push_back(mk(0, 1,4,2,1, 0,0,0,0,0, 0,0, 1,2,0,1,2,1));
        // Put answered with AccessAckData
        vt.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0));
        vt.push_back(mk(0, 1,0,3,0, 0,0,0,0,0, 0,0, 1,1,0,0,0,0));
        vt.push_back(mk(0, 0,0,0,0, 1,1,3,0,0, 0,0, 0,1,1,1,3,0));
        // A and D on a non-pending source in one cycle
        vt.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0));
        vt.push_back(mk(0, 1,4,3,4, 1,0,0,4,0, 0,0, 1,1,1,1,1,4));
        vt.push_back(mk(0, 0,0,0,0, 1,1,3,4,0, 0,0, 0,1,2,1,1,4));

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            else begin
                set_in(vt[i].av, vt[i].aop, vt[i].asz, vt[i].asrc, vt[i].dv, vt[i].dop,
                       vt[i].dsz, vt[i].dsrc, vt[i].dsink, vt[i].ev, vt[i].esink);
                step();
            end
            chk6($sformatf("vec%0d", i), vt[i].out, vt[i].acnt, vt[i].dcnt,
                 vt[i].err, vt[i].code, vt[i].id);
        end

        // AcquireBlock, 8-beat GrantData, GrantAck, then a stray GrantAck
        do_reset();
        set_in(1,6,6,2, 0,0,0,0,0, 0,0); step();
        chk6("acq", 1, 1, 0, 0, 0, 0);
        for (int b = 1; b <= 8; b++) begin
            set_in(0,0,0,0, 1,5,6,2,1, 0,0); step();
            if (b < 8) chk6($sformatf("gd%0d", b), 1, 1, 0, 0, 0, 0);
            else       chk6("gd8", 0, 1, 1, 0, 0, 0);
        end
        set_in(0,0,0,0, 0,0,0,0,0, 1,1); step();
        chk6("gack", 0, 1, 1, 0, 0, 0);
        set_in(0,0,0,0, 0,0,0,0,0, 1,1); step();
        chk6("gack2", 0, 1, 1, 1, 5, 1);

        // 8-beat Put counts one A first beat; next first beat is a duplicate
        do_reset();
        for (int b = 1; b <= 8; b++) begin
            set_in(1,0,6,3, 0,0,0,0,0, 0,0); step();
            chk6($sformatf("put%0d", b), 1, 1, 0, 0, 0, 0);
        end
        set_in(1,4,3,3, 0,0,0,0,0, 0,0); step();
        chk6("put_dup", 1, 2, 0, 1, 2, 3);

        // Legal reuse: last D beat and new A on the same source
        do_reset();
        set_in(1,4,3,6, 0,0,0,0,0, 0,0); step();
        set_in(1,4,3,6, 1,1,3,6,0, 0,0); step();
        chk6("reuse", 1, 2, 1, 0, 0, 0);

        // Grant and GrantAck for the same sink in one cycle
        do_reset();
        set_in(1,7,6,1, 0,0,0,0,0, 0,0); step();
        set_in(0,0,0,0, 1,4,0,1,2, 1,2); step();
        chk6("g_e_same", 0, 1, 1, 1, 5, 2);

        // Two grants on one sink
        do_reset();
        set_in(1,6,3,1, 0,0,0,0,0, 0,0); step();
        set_in(1,6,3,2, 1,4,0,1,0, 0,0); step();
        set_in(0,0,0,0, 1,4,0,2,0, 0,0); step();
        chk6("g_dup", 0, 2, 2, 1, 4, 0);

        // Simultaneous A_DUP and D_NO_REQ: lowest code reported
        do_reset();
        set_in(1,4,3,1, 0,0,0,0,0, 0,0); step();
        set_in(1,4,3,1, 1,0,0,5,0, 0,0); step();
        chk6("prio", 1, 2, 1, 1, 1, 5);

        // Stall watchdog
        do_reset();
        set_in(1,4,3,7, 0,0,0,0,0, 0,0); step();
        idle();
        for (int c = 0; c < c_TO - 1; c++) step();
        chk6("stall15", 1, 1, 0, 0, 0, 0);
        step();
`ifdef TL_CHECKER_TIMEOUT_EN
        chk6("stall16", 1, 1, 0, 1, 6, 7);
`else
        chk6("stall16", 1, 1, 0, 0, 0, 0);
`endif

        // Randomized traffic against the model
        for (int s = 0; s < 40; s++) begin
            do_reset();
            chk6($sformatf("rst%0d", s), 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 80; c++) begin
                rand_drive();
                step();
                chk6($sformatf("rnd%0d_%0d", s, c), m_out, m_acnt & 15, m_dcnt & 15,
                     m_err, m_code, m_id);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
